// File: rtl/fifo_nibble_reader.sv
// Read-side controller for a 4-bit FIFO: pops nibbles, packs NIBBLES of them LSB-first, presents on valid/ready.
// Optional even-parity output m_parity when PARITY_EN is defined.
//
// state | meaning
// FILL  | popping nibbles from the FIFO and collecting them into the partial word
// HOLD  | completed word presented on m_data/m_valid, waiting for m_ready
module fifo_nibble_reader #(
    parameter  int DIN_W   = 4,
    parameter  int NIBBLES = 2,
    localparam int OUT_W   = DIN_W * NIBBLES,
    localparam int CNT_W   = $clog2(NIBBLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [DIN_W-1:0] fifo_dout,
    output logic             fifo_rd_en,
    input  logic             flush,
    output logic [OUT_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
`ifdef PARITY_EN
    output logic             m_parity,
`endif
    output logic [CNT_W-1:0] nib_cnt
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               inflight_q, inflight_d;
    logic [CNT_W-1:0]   nib_cnt_q, nib_cnt_d;
    logic [OUT_W-1:0]   slots_q, slots_d;
    logic [OUT_W-1:0]   m_data_q, m_data_d;
    logic               m_valid_q, m_valid_d;
    logic               rd_en_c;
    logic [CNT_W:0]     pending;
`ifdef PARITY_EN
    logic               m_parity_q, m_parity_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            inflight_q <= 1'b0;
            nib_cnt_q  <= '0;
            slots_q    <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
`ifdef PARITY_EN
            m_parity_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            nib_cnt_q  <= nib_cnt_d;
            slots_q    <= slots_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
`ifdef PARITY_EN
            m_parity_q <= m_parity_d;
`endif
        end
    end

    // Nibbles already captured plus the one still in the FIFO read pipeline.
    assign pending = {1'b0, nib_cnt_q} + {{CNT_W{1'b0}}, inflight_q};

    always_comb begin
        state_d    = state_q;
        inflight_d = 1'b0;
        nib_cnt_d  = nib_cnt_q;
        slots_d    = slots_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        rd_en_c    = 1'b0;
`ifdef PARITY_EN
        m_parity_d = m_parity_q;
`endif
        case (state_q)
            FILL: begin
                // rst gating keeps the pop strobe low while reset is held, not just after an edge.
                rd_en_c    = !rst && !fifo_empty && !flush && (pending < (CNT_W+1)'(NIBBLES));
                inflight_d = rd_en_c;
                if (flush) begin
                    nib_cnt_d = '0;
                end else if (inflight_q) begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (nib_cnt_q == CNT_W'(i)) begin
                            slots_d[i*DIN_W +: DIN_W] = fifo_dout;
                        end
                    end
                    if (nib_cnt_q == CNT_W'(NIBBLES - 1)) begin
                        state_d   = HOLD;
                        m_valid_d = 1'b1;
                        m_data_d  = slots_d;
                        nib_cnt_d = '0;
`ifdef PARITY_EN
                        m_parity_d = ^slots_d;
`endif
                    end else begin
                        nib_cnt_d = nib_cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign fifo_rd_en = rd_en_c;
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign nib_cnt    = nib_cnt_q;
`ifdef PARITY_EN
    assign m_parity   = m_parity_q;
`endif

endmodule

// File: tb/tb_fifo_nibble_reader.sv
// Directed bench for fifo_nibble_reader with a small behavioural FIFO (1-cycle read latency).
// Define PARITY_EN to also cover m_parity.
module tb_fifo_nibble_reader;

    logic       clk;
    logic       rst;
    logic       fifo_empty;
    logic [3:0] fifo_dout;
    logic       fifo_rd_en;
    logic       flush;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [1:0] nib_cnt;
    logic       m_parity;

    int checks   = 0;
    int failures = 0;

    logic [3:0] mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    bit         underflow_seen = 0;

    fifo_nibble_reader #(.DIN_W(4), .NIBBLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
`ifdef PARITY_EN
        .m_parity   (m_parity),
`endif
        .nib_cnt    (nib_cnt)
    );

`ifndef PARITY_EN
    assign m_parity = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign fifo_empty = (wr_ptr == rd_ptr);

    // Behavioural FIFO; reset discards whatever is still queued.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= wr_ptr;
            fifo_dout <= 4'h0;
        end else if (fifo_rd_en) begin
            if (fifo_empty) underflow_seen <= 1'b1;
            fifo_dout <= mem[rd_ptr[5:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [3:0] n);
        mem[wr_ptr[5:0]] = n;
        wr_ptr++;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (m_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b1;
        push(4'h3);
        push(4'hA);
        #1;
        checks++;
        if ({fifo_rd_en, m_valid, nib_cnt, m_data} !== 12'h000) begin
            failures++;
            $display("FAIL reset_hold rd_en=%0b valid=%0b nib_cnt=%0d data=%h required 0,0,0,00",
                     fifo_rd_en, m_valid, nib_cnt, m_data);
        end
        step();
        rst = 1'b0;
        m_ready = 1'b0;
        push(4'h3);
        push(4'hA);
        #1;
        wait_valid(10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL reset_pre_hold timeout m_valid=%0b required 1", m_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({fifo_rd_en, m_valid, nib_cnt, m_data} !== 12'h000) begin
            failures++;
            $display("FAIL reset_in_hold rd_en=%0b valid=%0b nib_cnt=%0d data=%h required 0,0,0,00",
                     fifo_rd_en, m_valid, nib_cnt, m_data);
        end
        step();
        rst = 1'b0;
        push(4'h5);
        #1;
        step();
        step();
        checks++;
        if (nib_cnt !== 2'd1) begin
            failures++;
            $display("FAIL reset_pre_midword nib_cnt=%0d required 1", nib_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({fifo_rd_en, m_valid, nib_cnt} !== 4'h0) begin
            failures++;
            $display("FAIL reset_midword rd_en=%0b valid=%0b nib_cnt=%0d required 0,0,0",
                     fifo_rd_en, m_valid, nib_cnt);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_pack();
        logic [6:0] rd_seq;
        int         vcnt;
        int         vidx;
        logic [7:0] data;
        logic       par;
        rd_seq = '0;
        vcnt   = 0;
        vidx   = -1;
        data   = '0;
        par    = 1'b0;
        m_ready = 1'b1;
        push(4'h3);
        push(4'hA);
        #1;
        for (int i = 0; i < 7; i++) begin
            rd_seq[i] = fifo_rd_en;
            if (m_valid) begin
                vcnt++;
                if (vidx < 0) begin
                    vidx = i;
                    data = m_data;
                    par  = m_parity;
                end
            end
            step();
        end
        checks++;
        if (rd_seq !== 7'b0000011) begin
            failures++;
            $display("FAIL basic_rd_en_pattern got=%b required 0000011", rd_seq);
        end
        checks++;
        if (vcnt != 1 || vidx != 3) begin
            failures++;
            $display("FAIL basic_valid valid_cycles=%0d first_at=%0d required 1 at 3", vcnt, vidx);
        end
        checks++;
        if (data !== 8'hA3) begin
            failures++;
            $display("FAIL basic_data got=%h required a3", data);
        end
`ifdef PARITY_EN
        checks++;
        if (par !== 1'b0) begin
            failures++;
            $display("FAIL basic_parity got=%0b required 0", par);
        end
`endif
    endtask

    task automatic test_backpressure();
        bit ok;
        m_ready = 1'b0;
        push(4'h1);
        push(4'h2);
        push(4'h3);
        push(4'h4);
        #1;
        wait_valid(8, ok);
        checks++;
        if (!ok || m_data !== 8'h21) begin
            failures++;
            $display("FAIL bp_first_word valid=%0b data=%h required 1,21", m_valid, m_data);
        end
        for (int i = 0; i < 5; i++) begin
            flush = (i == 2);
            #1;
            checks++;
            if ({m_valid, fifo_rd_en, m_data} !== {1'b1, 1'b0, 8'h21}) begin
                failures++;
                $display("FAIL bp_hold_%0d valid=%0b rd_en=%0b data=%h required 1,0,21",
                         i, m_valid, fifo_rd_en, m_data);
            end
            step();
        end
        flush = 1'b0;
        m_ready = 1'b1;
        step();
        checks++;
        if (m_valid !== 1'b0 || fifo_rd_en !== 1'b1) begin
            failures++;
            $display("FAIL bp_after_accept valid=%0b rd_en=%0b required 0,1", m_valid, fifo_rd_en);
        end
        wait_valid(8, ok);
        checks++;
        if (!ok || m_data !== 8'h43) begin
            failures++;
            $display("FAIL bp_second_word valid=%0b data=%h required 1,43", m_valid, m_data);
        end
`ifdef PARITY_EN
        checks++;
        if (m_parity !== 1'b1) begin
            failures++;
            $display("FAIL bp_parity got=%0b required 1", m_parity);
        end
`endif
        step();
    endtask

    task automatic test_empty_stall();
        bit ok;
        m_ready = 1'b1;
        push(4'h5);
        #1;
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({nib_cnt, fifo_rd_en, m_valid} !== {2'd1, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL stall_%0d nib_cnt=%0d rd_en=%0b valid=%0b required 1,0,0",
                         i, nib_cnt, fifo_rd_en, m_valid);
            end
            step();
        end
        push(4'hC);
        #1;
        wait_valid(8, ok);
        checks++;
        if (!ok || m_data !== 8'hC5) begin
            failures++;
            $display("FAIL stall_word valid=%0b data=%h required 1,c5", m_valid, m_data);
        end
        step();
    endtask

    task automatic test_flush();
        bit ok;
        m_ready = 1'b1;
        push(4'h7);
        #1;
        step();
        step();
        flush = 1'b1;
        push(4'h9);
        #1;
        checks++;
        if (nib_cnt !== 2'd1 || fifo_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL flush_cycle nib_cnt=%0d rd_en=%0b required 1,0", nib_cnt, fifo_rd_en);
        end
        step();
        flush = 1'b0;
        checks++;
        if (nib_cnt !== 2'd0 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_cleared nib_cnt=%0d valid=%0b required 0,0", nib_cnt, m_valid);
        end
        push(4'h8);
        #1;
        wait_valid(8, ok);
        checks++;
        if (!ok || m_data !== 8'h89) begin
            failures++;
            $display("FAIL flush_word valid=%0b data=%h required 1,89", m_valid, m_data);
        end
        step();
        // flush coinciding with the final nibble capture
        push(4'h1);
        push(4'h2);
        #1;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        step();
        checks++;
        if (nib_cnt !== 2'd0 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_final nib_cnt=%0d valid=%0b required 0,0", nib_cnt, m_valid);
        end
        push(4'h6);
        push(4'hE);
        #1;
        wait_valid(8, ok);
        checks++;
        if (!ok || m_data !== 8'hE6) begin
            failures++;
            $display("FAIL flush_final_next valid=%0b data=%h required 1,e6", m_valid, m_data);
        end
        step();
        // flush while a nibble is in flight
        push(4'hB);
        #1;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        push(4'h4);
        push(4'hD);
        #1;
        wait_valid(8, ok);
        checks++;
        if (!ok || m_data !== 8'hD4) begin
            failures++;
            $display("FAIL flush_inflight valid=%0b data=%h required 1,d4", m_valid, m_data);
        end
        step();
    endtask

`ifdef PARITY_EN
    task automatic test_parity();
        bit ok;
        m_ready = 1'b1;
        push(4'h1);
        push(4'hA);
        #1;
        wait_valid(8, ok);
        checks++;
        if (!ok || m_data !== 8'hA1 || m_parity !== 1'b1) begin
            failures++;
            $display("FAIL parity_a1 valid=%0b data=%h parity=%0b required 1,a1,1",
                     m_valid, m_data, m_parity);
        end
        step();
    endtask
`endif

    task automatic test_no_underflow();
        checks++;
        if (underflow_seen) begin
            failures++;
            $display("FAIL underflow rd_en_while_empty=1 required 0");
        end
    endtask

    initial begin
        rst     = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        test_reset();
        test_basic_pack();
        test_backpressure();
        test_empty_stall();
        test_flush();
`ifdef PARITY_EN
        test_parity();
`endif
        test_no_underflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
